sram_wb_slave: RTL and testbench
================================

// Module: sram_wb_slave
// PURPOSE
//  Wishbone classic-cycle slave that serves the CPU's IF and data-memory Wishbone masters from one
//  external asynchronous 32-bit SRAM chip. Converts each request (cyc&stb) into a fixed-timing
//  SRAM read or byte-masked write, then returns a single-cycle ack. One instance per SRAM bank.
// PARAMETERS
//  ADDR_WIDTH       32  Wishbone address width (byte address)
//  DATA_WIDTH       32  Wishbone data width
//  SRAM_ADDR_WIDTH  20  SRAM word-address width
//  SRAM_DATA_WIDTH  32  SRAM data width (must equal DATA_WIDTH)
// PORTS
//  clk          in     1                  system clock, all logic on rising edge
//  reset        in     1                  synchronous, active-high reset
//  wb_cyc_i     in     1                  bus cycle valid
//  wb_stb_i     in     1                  strobe, request valid
//  wb_ack_o     out    1                  transfer done, one-cycle pulse
//  wb_adr_i     in     ADDR_WIDTH         byte address
//  wb_dat_i     in     DATA_WIDTH         write data
//  wb_dat_o     out    DATA_WIDTH         read data, valid while wb_ack_o=1
//  wb_sel_i     in     DATA_WIDTH/8       byte-lane enables
//  wb_we_i      in     1                  1=write, 0=read
//  sram_addr    out    SRAM_ADDR_WIDTH    SRAM word address
//  sram_data    inout  SRAM_DATA_WIDTH    SRAM data bus (tri-state)
//  sram_ce_n    out    1                  chip enable, active-low
//  sram_oe_n    out    1                  output enable, active-low
//  sram_we_n    out    1                  write enable, active-low
//  sram_be_n    out    SRAM_DATA_WIDTH/8  byte enables, active-low
// BEHAVIOUR
//  - All outputs registered. Reset values: wb_ack_o=0, wb_dat_o=0, sram_addr=0, sram_ce_n=1,
//    sram_oe_n=1, sram_we_n=1, sram_be_n=all 1s, sram_data released (Z). State=IDLE.
//  - Address mapping: sram_addr = wb_adr_i[SRAM_ADDR_WIDTH+1:2]; bits [1:0] and upper bits ignored.
//    sram_be_n = ~wb_sel_i. Address, sel, write data latched in IDLE when request accepted.
//  - FSM: IDLE, READ, READ_2, WRITE, WRITE_2, DONE.
//    IDLE:    cyc&stb&!we -> READ; cyc&stb&we -> WRITE; else stay. Strobes inactive.
//    READ:    ce_n=0, oe_n=0 (address settle) -> READ_2.
//    READ_2:  ce_n=0, oe_n=0; sram_data captured into wb_dat_o at end of cycle -> DONE.
//    WRITE:   ce_n=0, oe_n=1, sram_data driven with latched data, we_n=1 -> WRITE_2.
//    WRITE_2: ce_n=0, we_n=0, data still driven -> DONE.
//    DONE:    ce_n=1, oe_n=1, we_n=1, be_n all 1s, sram_data released; wb_ack_o=1 for this cycle
//             only -> IDLE.
//  - Latency: request sampled in IDLE at cycle T0; wb_ack_o high during T3 (read and write alike).
//    Back-to-back: if stb still high at T4 (IDLE), a new transfer starts; min period 4 cycles.
//  - sram_data driven only in WRITE and WRITE_2; never driven while oe_n=0 (no bus contention).
//    we_n never low in the same cycle data first goes valid or is released.
//  - wb_sel_i=0 on write: sequence runs normally, no byte lane written, ack still returned.
//  - wb_dat_o holds last read value until next read completes; unchanged by writes.
//  - cyc dropped mid-transfer: SRAM access completes through DONE, but wb_ack_o suppressed
//    (ack = DONE & wb_cyc_i); no retry.
//  - reset asserted in any state: next cycle returns to reset values above, write aborted with
//    we_n forced high; SRAM content for an interrupted write is undefined.
// TESTING
//  1 Read: SRAM model word 0x00010=0xDEADBEEF; cyc=stb=1,we=0,adr=0x00000040 -> ack at T3,
//    dat_o=0xDEADBEEF, sram_addr=0x00010, oe_n low in T1-T2 only.
//  2 Byte write: word 0x00010=0xDEADBEEF; we=1,adr=0x40,sel=4'b0010,dat=0x0000AB00 -> ack at T3;
//    readback 0xDEADABEF; be_n=4'b1101 during T1-T2, we_n low only in T2.
//  3 Back-to-back: write 0x11223344 to 0x80, keep stb high, then read 0x80 -> two acks at T3 and T7,
//    second returns 0x11223344; ack never high two consecutive cycles.
//  4 sel=0 write of 0xFFFFFFFF to 0x40 -> ack at T3, word unchanged, be_n stays 4'b1111.
//  5 Reset at T2 of a write -> T3: ce_n=we_n=1, sram_data=Z, ack=0, state IDLE; fresh read then
//    completes with normal 3-cycle latency.
//  6 cyc dropped at T1 of a read -> no ack in T3; FSM back in IDLE at T4; contention checker
//    (sram_data driven while oe_n=0) never fires over all scenarios.

Source files
------------

// File: rtl/sram_wb_slave.sv
// Wishbone classic-cycle slave in front of one asynchronous 32-bit SRAM bank.
// Each request becomes a fixed four-cycle SRAM read or byte-masked write ending in a one-cycle ack.
module sram_wb_slave #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  output logic                         wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  input  logic                         wb_we_i,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0]   sram_data,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n,
  output logic [2:0]                   dbg_state_o
);

  // Handshake: a request is cyc_i & stb_i sampled in IDLE; the slave answers with exactly one
  // ack cycle three cycles later (suppressed if cyc_i has dropped), and the master must not
  // expect a second transfer to start before the cycle after that ack.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    READ_2  = 3'd2,
    WRITE   = 3'd3,
    WRITE_2 = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                         state_q;
  logic                           ack_q;
  logic [DATA_WIDTH-1:0]          rdata_q;
  logic [SRAM_DATA_WIDTH-1:0]     wdata_q;
  logic [SRAM_ADDR_WIDTH-1:0]     addr_q;
  logic                           ce_n_q;
  logic                           oe_n_q;
  logic                           we_n_q;
  logic [SRAM_DATA_WIDTH/8-1:0]   be_n_q;
  logic                           drive_q;
  logic                           unused_adr_bits;

  assign unused_adr_bits = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

  // Strobes are computed for the state being entered, so every pin is a flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      drive_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            addr_q <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
            be_n_q <= ~wb_sel_i;
            ce_n_q <= 1'b0;
            if (wb_we_i) begin
              wdata_q <= wb_dat_i;
              drive_q <= 1'b1;
              oe_n_q  <= 1'b1;
              state_q <= WRITE;
            end else begin
              oe_n_q  <= 1'b0;
              state_q <= READ;
            end
          end
        end
        READ: state_q <= READ_2;
        READ_2: begin
          rdata_q <= sram_data;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          be_n_q  <= '1;
          ack_q   <= wb_cyc_i;
          state_q <= DONE;
        end
        // Data has been valid for a full cycle before we_n falls, and we_n rises with the release.
        WRITE: begin
          we_n_q  <= 1'b0;
          state_q <= WRITE_2;
        end
        WRITE_2: begin
          we_n_q  <= 1'b1;
          drive_q <= 1'b0;
          ce_n_q  <= 1'b1;
          be_n_q  <= '1;
          ack_q   <= wb_cyc_i;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_data   = drive_q ? wdata_q : {SRAM_DATA_WIDTH{1'bz}};
  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_wb_slave.sv
// Directed bench for sram_wb_slave with a behavioural asynchronous SRAM on the data bus.
// Each step drives the bus mid-cycle and samples DUT outputs at the falling edge.
module tb_sram_wb_slave;

  logic        clk;
  logic        reset;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic        mon_en = 1'b0;
  logic        prev_ack = 1'b0;

  localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd1, S_READ_2 = 3'd2,
                         S_WRITE = 3'd3, S_WRITE_2 = 3'd4, S_DONE = 3'd5;

  sram_wb_slave dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_ack_o(wb_ack),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // SRAM model: drives the bus while selected and output-enabled; writes land while we_n is low.
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
    end
  end

  // Bus-level protocol monitor across all scenarios.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (!(!sram_oe_n && (dbg_state == S_WRITE || dbg_state == S_WRITE_2))) else begin
        failures++;
        $error("FAIL contention observed=oe_n_low_in_state_%0d expected=no_drive", dbg_state);
      end
      checks++;
      assert (!(prev_ack && wb_ack)) else begin
        failures++;
        $error("FAIL ack_twice observed=1 expected=0");
      end
      checks++;
      assert (!(!sram_we_n && (sram_oe_n !== 1'b1 || sram_ce_n !== 1'b0))) else begin
        failures++;
        $error("FAIL we_strobe observed=oe_n=%b,ce_n=%b expected=oe_n=1,ce_n=0", sram_oe_n, sram_ce_n);
      end
      prev_ack = wb_ack;
    end
  end

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    wb_cyc = cyc; wb_stb = stb; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One complete transfer; reads push their expected word into the scoreboard.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat, input logic [31:0] rd_exp);
    int lat;
    logic [31:0] exp_w;
    lat = 0;
    if (!we) exp_q.push_back(rd_exp);
    drive(1'b1, 1'b1, we, adr, sel, dat);
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (wb_ack) lat = k;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    if (!we && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      if (lat != 0) chk({tag, "_rdata"}, wb_dat_r, exp_w);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    preload(8'h10, 32'hDEADBEEF);
    // reset values
    chk("rst_ack",   {31'd0, wb_ack}, 32'd0);
    chk("rst_dat",   wb_dat_r, 32'h0);
    chk("rst_addr",  {12'd0, sram_addr}, 32'h0);
    chk("rst_ce",    {31'd0, sram_ce_n}, 32'd1);
    chk("rst_oe",    {31'd0, sram_oe_n}, 32'd1);
    chk("rst_we",    {31'd0, sram_we_n}, 32'd1);
    chk("rst_be",    {28'd0, sram_be_n}, 32'hF);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // 1: single read, cycle by cycle
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
    @(negedge clk);
    chk("rd_t1_state", {29'd0, dbg_state}, {29'd0, S_READ});
    chk("rd_t1_addr",  {12'd0, sram_addr}, 32'h10);
    chk("rd_t1_oe",    {31'd0, sram_oe_n}, 32'd0);
    chk("rd_t1_ack",   {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    chk("rd_t2_oe",    {31'd0, sram_oe_n}, 32'd0);
    chk("rd_t2_ce",    {31'd0, sram_ce_n}, 32'd0);
    @(negedge clk);
    chk("rd_t3_ack",   {31'd0, wb_ack}, 32'd1);
    chk("rd_t3_dat",   wb_dat_r, 32'hDEADBEEF);
    chk("rd_t3_oe",    {31'd0, sram_oe_n}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd_t4_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("rd_t4_ack",   {31'd0, wb_ack}, 32'd0);

    // 2: byte-lane write, cycle by cycle
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 4'b0010, 32'h0000AB00);
    @(negedge clk);
    chk("wr_t1_state", {29'd0, dbg_state}, {29'd0, S_WRITE});
    chk("wr_t1_be",    {28'd0, sram_be_n}, 32'hD);
    chk("wr_t1_we",    {31'd0, sram_we_n}, 32'd1);
    chk("wr_t1_data",  sram_data, 32'h0000AB00);
    @(negedge clk);
    chk("wr_t2_we",    {31'd0, sram_we_n}, 32'd0);
    chk("wr_t2_be",    {28'd0, sram_be_n}, 32'hD);
    chk("wr_t2_data",  sram_data, 32'h0000AB00);
    @(negedge clk);
    chk("wr_t3_ack",   {31'd0, wb_ack}, 32'd1);
    chk("wr_t3_we",    {31'd0, sram_we_n}, 32'd1);
    chk("wr_t3_ce",    {31'd0, sram_ce_n}, 32'd1);
    chk("wr_t3_be",    {28'd0, sram_be_n}, 32'hF);
    chk("wr_t3_dat_o", wb_dat_r, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    xfer("wr_readback", 1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDEADABEF);
    @(negedge clk);

    // 3: back-to-back write then read with stb held high
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0080, 4'hF, 32'h11223344);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3 || k == 7) chk($sformatf("b2b_t%0d_ack", k), {31'd0, wb_ack}, 32'd1);
      else chk($sformatf("b2b_t%0d_ack", k), {31'd0, wb_ack}, 32'd0);
      if (k == 3) drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
      if (k == 7) chk("b2b_rdata", wb_dat_r, 32'h11223344);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // 4: sel=0 write leaves the word intact
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 4'h0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("sel0_t1_be", {28'd0, sram_be_n}, 32'hF);
    @(negedge clk);
    chk("sel0_t2_be", {28'd0, sram_be_n}, 32'hF);
    @(negedge clk);
    chk("sel0_t3_ack", {31'd0, wb_ack}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    xfer("sel0_readback", 1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDEADABEF);
    @(negedge clk);

    // 5: reset during the strobe cycle of a write
    drive(1'b1, 1'b1, 1'b1, 32'h0000_00C0, 4'hF, 32'h55AA55AA);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_t2_we", {31'd0, sram_we_n}, 32'd0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rstw_t3_ce",    {31'd0, sram_ce_n}, 32'd1);
    chk("rstw_t3_we",    {31'd0, sram_we_n}, 32'd1);
    chk("rstw_t3_ack",   {31'd0, wb_ack}, 32'd0);
    chk("rstw_t3_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    reset = 1'b0;
    xfer("rstw_fresh_read", 1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDEADABEF);
    @(negedge clk);

    // 6: cyc dropped during a read
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
    @(negedge clk);
    chk("drop_t1_state", {29'd0, dbg_state}, {29'd0, S_READ});
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("drop_t2_state", {29'd0, dbg_state}, {29'd0, S_READ_2});
    @(negedge clk);
    chk("drop_t3_state", {29'd0, dbg_state}, {29'd0, S_DONE});
    chk("drop_t3_ack",   {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    chk("drop_t4_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("drop_t4_ack",   {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    mon_en = 1'b0;

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
